// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: fixed wait states, stall, error pulse, store counter.
// Optional halt register at HALT_ADDR is built only when DMEM_MMIO_EN is defined.
module dmem_responder #(
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] HALT_ADDR   = 32'h54
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  output logic [15:0] store_count,
  output logic        halt,
  output logic [31:0] halt_value
);

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam int         DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q;
  logic [15:0]        store_count_q;
  logic [31:0]        mem_q [DEPTH];

  logic               req_s;
  logic               last_s;
  logic               complete_s;
  logic               illegal_s;
  logic               store_ok_s;
  logic               mem_we_s;
  logic [3:0]         cnt_inc_s;
  logic [ADDR_W-1:0]  idx_s;

  assign req_s      = memread | memwrite;
  assign last_s     = (cnt_q == WS);
  assign cnt_inc_s  = cnt_q + 4'd1;
  assign idx_s      = dataadr[ADDR_W+1:2];
  assign stall      = req_s & ~last_s & ~reset;
  assign complete_s = req_s & last_s & ~reset;

  // Misaligned, out-of-range or simultaneous read+write are all rejected at completion.
  assign illegal_s  = (dataadr[1:0] != 2'b00)
                    | (dataadr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}})
                    | (memread & memwrite);
  assign store_ok_s = complete_s & memwrite & ~illegal_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (req_s && !last_s) begin
          cnt_d   = cnt_inc_s;
          state_d = (cnt_inc_s == WS) ? S_DONE : S_WAIT;
        end else begin
          // Either completed in this cycle (WS == 0) or the request was dropped.
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      err_q         <= 1'b0;
      store_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= complete_s & illegal_s;
      if (store_ok_s && (store_count_q != 16'hFFFF)) begin
        store_count_q <= store_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= writedata;
    end
  end

  assign err         = err_q;
  assign store_count = store_count_q;

`ifdef DMEM_MMIO_EN
  logic        halt_hit_s;
  logic        halt_q;
  logic [31:0] halt_value_q;

  assign halt_hit_s = (dataadr == HALT_ADDR);
  assign mem_we_s   = store_ok_s & ~halt_hit_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q       <= 1'b0;
      halt_value_q <= 32'd0;
    end else if (store_ok_s && halt_hit_s) begin
      halt_q       <= 1'b1;
      halt_value_q <= writedata;
    end
  end

  always_comb begin
    readdata = mem_q[idx_s];
    if (complete_s && illegal_s) begin
      readdata = 32'd0;
    end else if (halt_hit_s) begin
      readdata = halt_value_q;
    end else begin
      readdata = mem_q[idx_s];
    end
  end

  assign halt       = halt_q;
  assign halt_value = halt_value_q;
`else
  assign mem_we_s = store_ok_s;

  always_comb begin
    readdata = mem_q[idx_s];
    if (complete_s && illegal_s) begin
      readdata = 32'd0;
    end else begin
      readdata = mem_q[idx_s];
    end
  end

  assign halt       = 1'b0;
  assign halt_value = 32'd0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the pipeline's MEM-stage load/store interface (memread/memwrite/dataadr/writedata).
- Answers CPU loads and stores with a configurable number of wait states and drives a stall back to the pipeline hazard unit.
- Flags illegal accesses and counts completed stores, so benches and FPGA builds can exercise the pipeline against a slow memory instead of an ideal single-cycle one.

Parameters:
- ADDR_W, 6, word-address width; memory depth is 2**ADDR_W 32-bit words.
- WAIT_STATES, 2, stall cycles inserted per access (0 to 15).
- HALT_ADDR, 32'h54, byte address of the halt register (used only with DMEM_MMIO_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memread  in  1  load request from the MEM stage.
- memwrite  in  1  store request from the MEM stage.
- dataadr  in  32  byte address (ALU result).
- writedata  in  32  store data.
- readdata  out  32  load data.
- stall  out  1  freeze pipeline; the request must be held stable while high.
- err  out  1  one-cycle pulse: illegal access completed.
- store_count  out  16  number of completed legal stores, saturating.
- halt  out  1  halt register set (DMEM_MMIO_EN only; tied 0 otherwise).
- halt_value  out  32  data stored to HALT_ADDR (DMEM_MMIO_EN only; 0 otherwise).

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - wait counter 0, stall 0, err 0, store_count 0, halt 0, halt_value 0.
  - Memory array is not cleared by reset.
- req = memread | memwrite. FSM states:
  - IDLE: no request pending, counter = 0.
  - WAIT: counter < WAIT_STATES.
  - DONE: counter == WAIT_STATES.
- Transitions and stall:
  - In IDLE with req, count from 0 while the request is held.
  - stall = req & (counter != WAIT_STATES), combinational. stall is forced 0 while reset is high.
  - Completion happens in the cycle where req is high and stall is low.
  - The counter returns to 0 at the following edge, so the next request (a new instruction) restarts the count.
  - With WAIT_STATES = 0, stall never asserts and every access completes in its first cycle.
- Latency: an access presented at cycle t completes at the rising edge ending cycle t+WAIT_STATES.
- Store:
  - mem[dataadr[ADDR_W+1:2]] <= writedata only at the completion edge.
  - store_count increments at the same edge and saturates at 16'hFFFF.
- Load: readdata = mem[dataadr[ADDR_W+1:2]], combinational. It is valid in the completion cycle and may change freely during stall.
- Illegal access = any of:
  - dataadr[1:0] != 0;
  - dataadr bits above ADDR_W+1 nonzero;
  - memread & memwrite both high.
- On an illegal access:
  - full wait sequence still runs;
  - at completion no write occurs and store_count is unchanged;
  - readdata = 0 in the completion cycle;
  - err pulses high for exactly the cycle after completion.
- Request dropped mid-wait (req falls before completion): counter returns to 0 at the next edge, nothing is written, no err.
- Reset mid-wait: counter cleared, pending store discarded, memory unchanged.

Optional Feature:
- Macro DMEM_MMIO_EN.
- When defined:
  - A legal store to HALT_ADDR does not write the array.
  - At completion it sets halt = 1 and halt_value = writedata; both stay sticky until reset.
  - store_count still increments.
  - Loads from HALT_ADDR return halt_value.
  - A second store to HALT_ADDR overwrites halt_value.
- When undefined: HALT_ADDR is ordinary memory, and halt/halt_value are constant 0.

Test Plan:
- WAIT_STATES=2, store 7 to 0x54 (memwrite held) -> stall high 2 cycles, low in the 3rd; mem[21]=7 after that edge; store_count 0->1.
- After the previous store, load 0x54 -> stall 2 cycles; readdata=32'h7 in the completion cycle; no write, store_count unchanged.
- Store 5 to 0x55 (misaligned) -> stall 2 cycles; no write (mem[21] stays 7); err=1 for one cycle; store_count unchanged.
- memread=memwrite=1 at 0x10 -> treated as illegal: err pulse, mem[4] unchanged, readdata=0 at completion.
- Store 9 to 0x08; assert reset for one cycle after the first stall cycle -> stall 0 during reset; mem[2] unchanged; store_count=0; replayed store then completes after 2 fresh stall cycles.
- DMEM_MMIO_EN, store 7 to 0x54 -> halt=1, halt_value=7, mem[21] untouched; load 0x54 returns 7. Without the macro, same stimulus -> halt=0, mem[21]=7.
